// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package debounce_pkg;

  // Per-channel debounced state: released or pressed.
  typedef enum logic {
    DB_IDLE    = 1'b0,
    DB_PRESSED = 1'b1
  } db_state_t;

  // Width of a counter that has to hold every value from 0 to n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// One debouncer channel: a 2-FF synchroniser, optional polarity inversion,
// a settle counter that drives a two-state FSM, and a saturating hold
// counter that produces a single long-press strobe per press.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 200,
  parameter int HOLD_CYCLES   = 25000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_release_p,
  output logic o_long_press
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);

  // Raw pin level that means "not pressed"; also used as the inversion mask.
  localparam logic RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  db_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          r_release;
  logic [HW-1:0] r_hcnt;
  logic          r_long;

  logic          w_s;
  logic          w_level;
  db_state_t     w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_press_nxt;
  logic          w_release_nxt;
  logic [HW-1:0] w_hcnt_nxt;
  logic          w_long_nxt;

  // Synchronised sample, normalised so that 1 always means pressed.
  assign w_s     = r_sync2 ^ RAW_IDLE;
  assign w_level = (r_state == DB_PRESSED);

  // Two-stage synchroniser for the asynchronous pin.
  // NOTE: the sync flops clear to the idle pin level, otherwise an
  // active-low channel would see a phantom press right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RAW_IDLE;
      r_sync2 <= RAW_IDLE;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
      // giving two real stages rather than one collapsed flop.
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  // Settle counter and FSM next state: accept a change only after
  // STABLE_CYCLES consecutive differing samples; any match restarts.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no
    // path leaves a signal unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    if (w_s != w_level) begin
      if (r_cnt == CNT_LAST) begin
        unique case (r_state)
          DB_IDLE: begin
            w_state_nxt = DB_PRESSED;
            w_press_nxt = 1'b1;
          end
          DB_PRESSED: begin
            w_state_nxt   = DB_IDLE;
            w_release_nxt = 1'b1;
          end
          default: w_state_nxt = DB_IDLE;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  // State, settle count and edge strobes are registered together so the
  // strobes coincide with the level change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DB_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Hold counter: clears while released, saturates at HOLD_CYCLES, and the
  // long-press strobe fires on the single step into saturation.
  always_comb begin
    w_hcnt_nxt = r_hcnt;
    w_long_nxt = 1'b0;
    if (!w_level) begin
      w_hcnt_nxt = '0;
    end else if (r_hcnt != HOLD_MAX) begin
      w_hcnt_nxt = r_hcnt + HW'(1);
      w_long_nxt = (r_hcnt == HOLD_LAST);
    end
  end

  // Hold counter and long-press strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_long <= w_long_nxt;
    end
  end

  assign o_level      = w_level;
  assign o_press      = r_press;
  assign o_release_p  = r_release;
  assign o_long_press = r_long;

endmodule : debounce_channel

// File: rtl/debounce_multi.sv
// N-channel button debouncer: one independent debounce_channel per input.
// There is no logic shared between channels.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 200,
  parameter int HOLD_CYCLES   = 25000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_press
);

  // One debouncer per channel.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_button    (button[g]),
      .o_level     (level[g]),
      .o_press     (press[g]),
      .o_release_p (release_p[g]),
      .o_long_press(long_press[g])
    );
  end

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: an active-high and an active-low
// instance share clock and reset; expected values are hand-derived edge counts.
module tb_debounce_multi;

  localparam int N_CH   = 4;
  localparam int STABLE = 8;
  localparam int HOLD   = 20;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] button,    button_al;
  logic [N_CH-1:0] level,     level_al;
  logic [N_CH-1:0] press,     press_al;
  logic [N_CH-1:0] release_p, release_al;
  logic [N_CH-1:0] long_press, long_al;

  int n_total;
  int n_pass;
  int press_cnt[N_CH];
  int rel_cnt[N_CH];
  int long_cnt[N_CH];

  debounce_multi #(
    .N_CH(N_CH), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .level(level),
    .press(press), .release_p(release_p), .long_press(long_press)
  );

  debounce_multi #(
    .N_CH(N_CH), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .button(button_al), .level(level_al),
    .press(press_al), .release_p(release_al), .long_press(long_al)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N_CH; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c]   = 0;
      long_cnt[c]  = 0;
    end
  endtask

  // Advance n rising edges, sampling 1 ns after each and tallying strobes.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < N_CH; c++) begin
        press_cnt[c] += int'(press[c]);
        rel_cnt[c]   += int'(release_p[c]);
        long_cnt[c]  += int'(long_press[c]);
      end
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clear_counts();

    // 1: reset with all pins high, then release with pins idle.
    rst_n     = 1'b0;
    button    = 4'hF;
    button_al = 4'hF;
    tick(3);
    check("rst_level",   level,      4'h0);
    check("rst_press",   press,      4'h0);
    check("rst_release", release_p,  4'h0);
    check("rst_long",    long_press, 4'h0);
    check("rst_level_al", level_al,  4'h0);
    rst_n  = 1'b1;
    button = 4'h0;
    clear_counts();
    tick(15);
    check("idle_level",    level,    4'h0);
    check("idle_level_al", level_al, 4'h0);
    check("idle_press_cnt", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    check("idle_rel_cnt",   rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);

    // 2: bounce on ch0, then held high; level follows 10 edges after settle.
    clear_counts();
    button[0] = 1'b1; tick(3);
    button[0] = 1'b0; tick(3);
    button[0] = 1'b1;
    tick(9);
    check("bounce_level_early", level[0], 1'b0);
    check("bounce_press_early", press_cnt[0], 0);
    tick(1);
    check("bounce_level", level[0], 1'b1);
    check("bounce_press", press, 4'b0001);
    tick(1);
    check("bounce_press_end", press[0], 1'b0);
    check("bounce_press_cnt", press_cnt[0], 1);

    // 3: ch0 held 12 cycles in total, then released; no long press.
    tick(1);
    clear_counts();
    button[0] = 1'b0;
    tick(9);
    check("rel_level_early", level[0], 1'b1);
    tick(1);
    check("rel_level",   level[0], 1'b0);
    check("rel_strobe",  release_p, 4'b0001);
    check("rel_no_press", press[0], 1'b0);
    tick(1);
    check("rel_strobe_end", release_p[0], 1'b0);
    tick(30);
    check("rel_cnt",     rel_cnt[0], 1);
    check("rel_no_long", long_cnt[0], 0);

    // 4: ch1 held 40 cycles; press at 10, one long press 20 later.
    clear_counts();
    button[1] = 1'b1;
    tick(10);
    check("long_press1", press, 4'b0010);
    check("long_level1", level, 4'b0010);
    tick(19);
    check("long_early", long_press[1], 1'b0);
    tick(1);
    check("long_fire", long_press, 4'b0010);
    tick(1);
    check("long_end", long_press[1], 1'b0);
    tick(9);
    check("long_cnt_held", long_cnt[1], 1);
    button[1] = 1'b0;
    tick(12);
    check("long_released", level, 4'h0);
    check("long_cnt_total", long_cnt[1], 1);
    check("long_rel_cnt", rel_cnt[1], 1);

    // 5: active-low instance, two channels pressed together then released.
    button_al = 4'b0101;
    tick(9);
    check("pol_level_early", level_al, 4'h0);
    tick(1);
    check("pol_level", level_al, 4'b1010);
    check("pol_press", press_al, 4'b1010);
    check("pol_no_rel", release_al, 4'h0);
    button_al = 4'hF;
    tick(10);
    check("pol_release_level", level_al, 4'h0);
    check("pol_release", release_al, 4'b1010);

    // 6: async reset while ch2 is mid-count and ch3 is pressed.
    button[3] = 1'b1;
    tick(12);
    check("arst_pre_level", level, 4'b1000);
    clear_counts();
    button[2] = 1'b1;
    tick(7);
    #4 rst_n = 1'b0;
    #1;
    check("arst_level_now", level, 4'h0);
    check("arst_strobes_now", {press, release_p, long_press}, 12'h000);
    tick(2);
    rst_n = 1'b1;
    tick(9);
    check("arst_level_early", level, 4'h0);
    check("arst_no_rel", rel_cnt[2] + rel_cnt[3], 0);
    tick(1);
    check("arst_level", level, 4'b1100);
    check("arst_press", press, 4'b1100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_debounce_multi
